id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS R2000 pipeline. Sits directly downstream of IF and consumes its pc_out/inst_out.
- Holds the 32x32 register file and decodes fields and immediates.
- Resolves beq/bne/j in ID and feeds the target and select back to IF.
- Detects load-use hazards and registers the ID/EX pipeline word.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/id_regfile.sv | 42 ++++
 rtl/id_stage.sv | 119 +++++++++++
 tb/tb_id_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS R2000 types, opcode constants and decode helpers for the ID stage.
package mips_pkg;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;
   typedef logic [5:0]  opcode_t;

   localparam opcode_t OP_RTYPE = 6'h00;
   localparam opcode_t OP_J     = 6'h02;
   localparam opcode_t OP_BEQ   = 6'h04;
   localparam opcode_t OP_BNE   = 6'h05;
   localparam opcode_t OP_ADDI  = 6'h08;
   localparam opcode_t OP_ADDIU = 6'h09;
   localparam opcode_t OP_SLTI  = 6'h0A;
   localparam opcode_t OP_ANDI  = 6'h0C;
   localparam opcode_t OP_ORI   = 6'h0D;
   localparam opcode_t OP_XORI  = 6'h0E;
   localparam opcode_t OP_LUI   = 6'h0F;
   localparam opcode_t OP_LW    = 6'h23;
   localparam opcode_t OP_SW    = 6'h2B;

   function automatic logic op_supported(opcode_t op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Opcodes whose rt field is a source operand rather than a destination.
   function automatic logic op_uses_rt(opcode_t op);
      case (op)
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic word_t extend_imm(opcode_t op, logic [15:0] imm);
      case (op)
         OP_ANDI, OP_ORI, OP_XORI: return {16'h0000, imm};
         OP_LUI:                   return {imm, 16'h0000};
         default:                  return {{16{imm[15]}}, imm};
      endcase
   endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file: two read ports with write-through bypass, one write port, r0 fixed at zero.
module id_regfile
   import mips_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   input  reg_idx_t ra1,
   input  reg_idx_t ra2,
   input  logic     we,
   input  reg_idx_t wa,
   input  word_t    wd,
   output word_t    rd1,
   output word_t    rd2
);

   word_t mem [NREG];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   // A same-cycle writeback to the register being read wins over the stored value.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != '0) begin
         rd1 = (we && wa == ra1) ? wd : mem[ra1];
      end
      if (ra2 != '0) begin
         rd2 = (we && wa == ra2) ? wd : mem[ra2];
      end
   end

endmodule

// File: rtl/id_stage.sv
// MIPS R2000 instruction-decode stage: register read, immediate decode, branch
// resolution, load-use hazard detection and the ID/EX pipeline register.
module id_stage
   import mips_pkg::*;
#(
   parameter int    NREG     = 32,
   parameter word_t RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   input  logic [31:0] inst_in,
   input  logic        valid_in,
   input  logic        flush,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic        br,
   output logic [31:0] sign,
   output logic [31:0] fixed,
   output logic        jump,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic [31:0] imm_ext,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        ill_inst
);

   opcode_t  dec_op;
   reg_idx_t dec_rs, dec_rt, dec_rd;
   word_t    dec_imm, rd_rs, rd_rt, pc4;

   assign dec_op  = inst_in[31:26];
   assign dec_rs  = inst_in[25:21];
   assign dec_rt  = inst_in[20:16];
   assign dec_rd  = inst_in[15:11];
   assign dec_imm = extend_imm(dec_op, inst_in[15:0]);
   assign pc4     = pc_in + 32'd4;

   id_regfile #(.NREG(NREG)) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (dec_rs),
      .ra2   (dec_rt),
      .we    (wb_en),
      .wa    (wb_addr),
      .wd    (wb_data),
      .rd1   (rd_rs),
      .rd2   (rd_rt)
   );

   // Load in EX targets a register this instruction reads: hold IF/ID one cycle.
   assign stall = valid_in & ex_mem_read & (ex_rt != '0)
                & ((ex_rt == dec_rs) | (op_uses_rt(dec_op) & (ex_rt == dec_rt)));

   assign sign  = pc4 + (dec_imm << 2);
   assign fixed = {pc4[31:28], inst_in[25:0], 2'b00};

   always_comb begin
      br   = 1'b0;
      jump = 1'b0;
      if (valid_in && !stall) begin
         case (dec_op)
            OP_BEQ:  br = (rd_rs == rd_rt);
            OP_BNE:  br = (rd_rs != rd_rt);
            OP_J: begin
               br   = 1'b1;
               jump = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Flush outranks stall; both leave a bubble, only a clean cycle loads the fields.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         ill_inst  <= 1'b0;
         pc_out    <= RESET_PC;
         rs_data   <= '0;
         rt_data   <= '0;
         imm_ext   <= '0;
         rs        <= '0;
         rt        <= '0;
         rd        <= '0;
         shamt     <= '0;
         opcode    <= '0;
         funct     <= '0;
      end else if (flush || stall) begin
         valid_out <= 1'b0;
         ill_inst  <= 1'b0;
      end else begin
         valid_out <= valid_in;
         ill_inst  <= valid_in & ~op_supported(dec_op);
         pc_out    <= pc_in;
         rs_data   <= rd_rs;
         rt_data   <= rd_rt;
         imm_ext   <= dec_imm;
         rs        <= dec_rs;
         rt        <= dec_rt;
         rd        <= dec_rd;
         shamt     <= inst_in[10:6];
         opcode    <= dec_op;
         funct     <= inst_in[5:0];
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed cases with literal expectations, then random
// traffic checked every cycle against a behavioural model of the stage.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_in, inst_in, wb_data;
   logic        valid_in, flush, ex_mem_read, wb_en;
   logic [4:0]  ex_rt, wb_addr;
   logic        stall, br, jump, valid_out, ill_inst;
   logic [31:0] sign, fixed, pc_out, rs_data, rt_data, imm_ext;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  opcode, funct;

   int total = 0;
   int bad   = 0;

   id_stage #(.NREG(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_in(inst_in),
      .valid_in(valid_in), .flush(flush), .ex_mem_read(ex_mem_read),
      .ex_rt(ex_rt), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall(stall), .br(br), .sign(sign), .fixed(fixed), .jump(jump),
      .valid_out(valid_out), .pc_out(pc_out), .rs_data(rs_data),
      .rt_data(rt_data), .imm_ext(imm_ext), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .opcode(opcode), .funct(funct), .ill_inst(ill_inst)
   );

   always #5 clk = ~clk;

   // Architectural model state and expected ID/EX contents.
   logic [31:0] regs [32];
   logic        e_known = 1'b0, e_ill_known = 1'b0, e_fields_known = 1'b0;
   logic        e_valid, e_ill;
   logic [31:0] e_pc, e_rsd, e_rtd, e_imm;
   logic [4:0]  e_rs, e_rt, e_rd, e_sh;
   logic [5:0]  e_op, e_fn;

   logic        n_ill_known, n_fields_known, n_valid, n_ill;
   logic [31:0] n_pc, n_rsd, n_rtd, n_imm;
   logic [4:0]  n_rs, n_rt, n_rd, n_sh;
   logic [5:0]  n_op, n_fn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_ext(input logic [31:0] inst);
      logic [5:0] op = inst[31:26];
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0, inst[15:0]};
      if (op == 6'h0F) return {inst[15:0], 16'h0};
      return {{16{inst[15]}}, inst[15:0]};
   endfunction

   function automatic logic m_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                        6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (wb_en && wb_addr == idx) return wb_data;
      return regs[idx];
   endfunction

   function automatic logic [31:0] r_type(input int s, input int t, input int d, input int f);
      return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
   endfunction

   function automatic logic [31:0] i_type(input int op, input int s, input int t, input int imm);
      return {6'(op), 5'(s), 5'(t), 16'(imm)};
   endfunction

   // Inputs are already driven; check combinational outputs and work out the next ID/EX word.
   task automatic check_comb();
      logic [5:0]  op;
      logic [4:0]  s, t;
      logic        ex_stall, ex_br, ex_jump, rt_src;
      logic [31:0] a, b;
      #1;
      op = inst_in[31:26];
      s  = inst_in[25:21];
      t  = inst_in[20:16];
      a  = m_read(s);
      b  = m_read(t);
      rt_src   = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
      ex_stall = valid_in && ex_mem_read && ex_rt != 0 && (ex_rt == s || (rt_src && ex_rt == t));
      ex_br    = 1'b0;
      ex_jump  = 1'b0;
      if (valid_in && !ex_stall) begin
         if (op == 6'h04) ex_br = (a == b);
         if (op == 6'h05) ex_br = (a != b);
         if (op == 6'h02) begin ex_br = 1'b1; ex_jump = 1'b1; end
      end
      chk("stall", 32'(stall), 32'(ex_stall));
      chk("br",    32'(br),    32'(ex_br));
      chk("jump",  32'(jump),  32'(ex_jump));
      chk("sign",  sign,  pc_in + 32'd4 + m_ext(inst_in) * 4);
      chk("fixed", fixed, ((pc_in + 32'd4) & 32'hF000_0000) | ((inst_in & 32'h03FF_FFFF) * 4));

      n_valid = 1'b0; n_ill = 1'b0; n_ill_known = 1'b1; n_fields_known = 1'b1;
      n_pc = e_pc; n_rsd = e_rsd; n_rtd = e_rtd; n_imm = e_imm;
      n_rs = e_rs; n_rt = e_rt; n_rd = e_rd; n_sh = e_sh; n_op = e_op; n_fn = e_fn;
      if (!rst_n) begin
         n_pc = 32'h0; n_rsd = 0; n_rtd = 0; n_imm = 0;
         n_rs = 0; n_rt = 0; n_rd = 0; n_sh = 0; n_op = 0; n_fn = 0;
      end else if (flush) begin
         n_fields_known = 1'b0;
      end else if (ex_stall) begin
         n_ill_known = 1'b0;
         n_fields_known = 1'b0;
      end else begin
         n_valid = valid_in;
         n_ill   = valid_in && !m_legal(op);
         n_pc = pc_in; n_rsd = a; n_rtd = b; n_imm = m_ext(inst_in);
         n_rs = s; n_rt = t; n_rd = inst_in[15:11]; n_sh = inst_in[10:6];
         n_op = op; n_fn = inst_in[5:0];
      end
   endtask

   // Clock edge: advance model, then compare the ID/EX register.
   task automatic check_edge();
      logic upd_we = rst_n && wb_en && wb_addr != 0;
      logic [4:0]  upd_a = wb_addr;
      logic [31:0] upd_d = wb_data;
      logic        was_rst = !rst_n;
      @(posedge clk);
      #1;
      if (was_rst) begin
         for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      end else if (upd_we) begin
         regs[upd_a] = upd_d;
      end
      if (was_rst) e_known = 1'b1;
      e_valid = n_valid; e_ill = n_ill;
      e_ill_known = n_ill_known; e_fields_known = n_fields_known;
      e_pc = n_pc; e_rsd = n_rsd; e_rtd = n_rtd; e_imm = n_imm;
      e_rs = n_rs; e_rt = n_rt; e_rd = n_rd; e_sh = n_sh; e_op = n_op; e_fn = n_fn;
      if (e_known) begin
         chk("valid_out", 32'(valid_out), 32'(e_valid));
         if (e_ill_known) chk("ill_inst", 32'(ill_inst), 32'(e_ill));
         if (e_fields_known) begin
            chk("pc_out",  pc_out,  e_pc);
            chk("rs_data", rs_data, e_rsd);
            chk("rt_data", rt_data, e_rtd);
            chk("imm_ext", imm_ext, e_imm);
            chk("rs", 32'(rs), 32'(e_rs));
            chk("rt", 32'(rt), 32'(e_rt));
            chk("rd", 32'(rd), 32'(e_rd));
            chk("shamt",  32'(shamt),  32'(e_sh));
            chk("opcode", 32'(opcode), 32'(e_op));
            chk("funct",  32'(funct),  32'(e_fn));
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst_n = 1'b1; valid_in = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 0;
      wb_en = 1'b0; wb_addr = 0; wb_data = 0; pc_in = 0; inst_in = 0;
   endtask

   task automatic write_reg(input int idx, input logic [31:0] val);
      idle_inputs();
      wb_en = 1'b1; wb_addr = 5'(idx); wb_data = val;
      check_comb();
      check_edge();
   endtask

   logic [5:0] op_pool [15] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01};

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) begin check_comb(); check_edge(); end
      chk("lit_reset_valid", 32'(valid_out), 32'd0);
      chk("lit_reset_pc", pc_out, 32'h0);
      chk("lit_reset_ill", 32'(ill_inst), 32'd0);

      idle_inputs();
      inst_in = r_type(5, 0, 1, 32'h20);
      check_comb(); check_edge();
      chk("lit_r5_zero", rs_data, 32'h0);

      idle_inputs();
      valid_in = 1'b1; inst_in = r_type(8, 0, 9, 32'h20);
      wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEAD_BEEF;
      check_comb(); check_edge();
      chk("lit_bypass_rs", rs_data, 32'hDEAD_BEEF);
      chk("lit_bypass_valid", 32'(valid_out), 32'd1);

      idle_inputs();
      valid_in = 1'b1; inst_in = r_type(0, 8, 9, 32'h20);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
      check_comb(); check_edge();
      chk("lit_r0_rs", rs_data, 32'h0);
      chk("lit_r8_held", rt_data, 32'hDEAD_BEEF);

      idle_inputs();
      valid_in = 1'b1; inst_in = r_type(8, 10, 9, 32'h20);
      ex_mem_read = 1'b1; ex_rt = 5'd8;
      check_comb();
      chk("lit_stall_hi", 32'(stall), 32'd1);
      check_edge();
      chk("lit_stall_bubble", 32'(valid_out), 32'd0);
      ex_mem_read = 1'b0;
      check_comb();
      chk("lit_stall_lo", 32'(stall), 32'd0);
      check_edge();
      chk("lit_issue_valid", 32'(valid_out), 32'd1);

      write_reg(1, 32'd5);
      write_reg(2, 32'd5);
      idle_inputs();
      valid_in = 1'b1; pc_in = 32'h100; inst_in = i_type(4, 1, 2, 3);
      check_comb();
      chk("lit_beq_br", 32'(br), 32'd1);
      chk("lit_beq_jump", 32'(jump), 32'd0);
      chk("lit_beq_sign", sign, 32'h110);
      wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd6;
      check_comb();
      chk("lit_beq_not_taken", 32'(br), 32'd0);
      check_edge();

      idle_inputs();
      valid_in = 1'b1; pc_in = 32'h1000_0040; inst_in = {6'h02, 26'h000_0004};
      check_comb();
      chk("lit_j_br", 32'(br), 32'd1);
      chk("lit_j_jump", 32'(jump), 32'd1);
      chk("lit_j_fixed", fixed, 32'h1000_0010);
      inst_in = {6'h02, 26'h000_0010};
      check_comb();
      chk("lit_j_fixed2", fixed, 32'h1000_0040);
      check_edge();

      idle_inputs();
      valid_in = 1'b1; flush = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd1;
      inst_in = i_type(6'h3F, 1, 0, 0);
      check_comb();
      chk("lit_flush_stall", 32'(stall), 32'd1);
      check_edge();
      chk("lit_flush_valid", 32'(valid_out), 32'd0);
      chk("lit_flush_ill", 32'(ill_inst), 32'd0);
      flush = 1'b0; ex_mem_read = 1'b0;
      check_comb(); check_edge();
      chk("lit_ill_set", 32'(ill_inst), 32'd1);
      chk("lit_ill_valid", 32'(valid_out), 32'd1);

      for (int n = 0; n < 2000; n++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         valid_in    = ($urandom_range(0, 7) != 0);
         flush       = ($urandom_range(0, 9) == 0);
         ex_mem_read = ($urandom_range(0, 3) == 0);
         ex_rt       = 5'($urandom_range(0, 7));
         wb_en       = $urandom_range(0, 1) == 1;
         wb_addr     = 5'($urandom_range(0, 7));
         wb_data     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         pc_in       = $urandom & 32'hFFFF_FFFC;
         inst_in     = {op_pool[$urandom_range(0, 14)], 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 16'($urandom)};
         check_comb();
         check_edge();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
